mp_add_ctrl: RTL and testbench

- Multi-precision add/subtract sequencer for the shared 8-bit adder datapath.
- Latches two NBYTES-wide operands and walks them one byte per clock, least-significant byte first, through the 8-bit add.
- Carries between bytes in a registered carry flag.
- Presents the full-width result with a done pulse; sits between the processor control unit and the byte adder.

---
 rtl/mp_add_ctrl.sv | 140 ++++++++++++++
 tb/tb_mp_add_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mp_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mp_add_ctrl
// Purpose  : Multi-precision add/subtract sequencer that walks two NBYTES-wide
//            operands LSB-first through a shared 8-bit adder, one byte a clock.
// Revision : 1.0 - initial release
// ============================================================================

module mp_add_byte_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    output logic [7:0] r_o,
    output logic       cout_o
);
    assign {cout_o, r_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

module mp_add_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            busy_q;
    logic            done_q;
    logic            cout_q;

    logic [7:0]      w_a_byte;
    logic [7:0]      w_b_byte;
    logic [7:0]      w_r1;
    logic [7:0]      w_r2;
    logic            w_c1;
    logic            w_c2;
    logic            w_carry_d;

    assign w_a_byte = a_q[{idx_q, 3'b000} +: 8];
    assign w_b_byte = b_q[{idx_q, 3'b000} +: 8];

    mp_add_byte_adder u_add_ab (
        .a_i    (w_a_byte),
        .b_i    (w_b_byte),
        .r_o    (w_r1),
        .cout_o (w_c1)
    );

    // Incoming carry folded in by a second pass; c1 and c2 cannot both be set.
    mp_add_byte_adder u_add_cin (
        .a_i    (w_r1),
        .b_i    ({7'b0, carry_q}),
        .r_o    (w_r2),
        .cout_o (w_c2)
    );

    assign w_carry_d = w_c1 | w_c2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        // Subtract is a + ~b + 1, the +1 arriving as the initial carry.
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub;
                        idx_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    sum_q[{idx_q, 3'b000} +: 8] <= w_r2;
                    carry_q <= w_carry_d;
                    if (idx_q == LAST_IDX) begin
                        cout_q  <= w_carry_d;
                        idx_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_mp_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp_add_ctrl
// Purpose  : Self-checking bench for mp_add_ctrl (NBYTES=4) using a vector
//            table plus hand-written multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================

module tb_mp_add_ctrl;
    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk;
    logic         rst;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks;
    int errors;

    typedef struct {
        logic         sub;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
    } vec_t;

    vec_t vecs[8];

    mp_add_ctrl #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W:0] model(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        if (s) return {1'b0, x} + {1'b0, ~y} + 1'b1;
        else   return {1'b0, x} + {1'b0, y};
    endfunction

    // One operation from IDLE: checks busy, latency, busy length, result, pulse width.
    task automatic run_op(input string name, input logic s, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [W-1:0] es, input logic ec);
        int lat;
        int busy_cnt;
        start = 1'b1; sub = s; a = x; b = y;
        tick();
        start = 1'b0; sub = ~s; a = $urandom; b = $urandom;
        chk({name, "_busy_accept"}, 64'(busy), 64'd1);
        busy_cnt = 1;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            lat = c;
            if (done) break;
            if (busy) busy_cnt++;
        end
        chk({name, "_latency"}, 64'(lat), 64'(NBYTES));
        chk({name, "_busy_cycles"}, 64'(busy_cnt), 64'(NBYTES));
        chk({name, "_busy_at_done"}, 64'(busy), 64'd0);
        chk({name, "_sum"}, 64'(sum), 64'(es));
        chk({name, "_cout"}, 64'(cout), 64'(ec));
        tick();
        chk({name, "_done_width"}, 64'(done), 64'd0);
        chk({name, "_sum_hold"}, 64'(sum), 64'(es));
    endtask

    logic [W-1:0] ba[18];
    logic [W-1:0] bb[18];
    int           done_edges[$];
    int           ndone;
    logic [W:0]   m;

    initial begin
        checks = 0;
        errors = 0;
        vecs[0] = '{1'b0, 32'h00FF_00FF, 32'h0001_0001, 32'h0100_0100, 1'b0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1};
        vecs[4] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1};
        vecs[6] = '{1'b0, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0};
        vecs[7] = '{1'b1, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        tick();
        tick();
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_sum",  64'(sum),  64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        rst = 1'b0;
        a = 32'hDEAD_BEEF; b = 32'h1234_5678;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
            chk("idle_sum",  64'(sum),  64'd0);
        end

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b,
                   vecs[i].exp_sum, vecs[i].exp_cout);

        // start held high with operands changing every cycle
        for (int c = 0; c < 18; c++) begin
            ba[c] = $urandom;
            bb[c] = $urandom;
        end
        done_edges.delete();
        start = 1'b1;
        for (int c = 0; c < 18; c++) begin
            a = ba[c]; b = bb[c]; sub = c[0];
            tick();
            if (done) begin
                done_edges.push_back(c);
                if (c >= NBYTES) begin
                    m = model(((c - NBYTES) % 2) == 1, ba[c - NBYTES], bb[c - NBYTES]);
                    chk($sformatf("b2b_sum_e%0d", c), 64'(sum), 64'(m[W-1:0]));
                    chk($sformatf("b2b_cout_e%0d", c), 64'(cout), 64'(m[W]));
                end
            end
        end
        start = 1'b0;
        chk("b2b_done_count", 64'(done_edges.size()), 64'd3);
        if (done_edges.size() >= 1) chk("b2b_first_done", 64'(done_edges[0]), 64'(NBYTES));
        if (done_edges.size() >= 2) chk("b2b_spacing0", 64'(done_edges[1] - done_edges[0]), 64'd6);
        if (done_edges.size() >= 3) chk("b2b_spacing1", 64'(done_edges[2] - done_edges[1]), 64'd6);
        for (int c = 0; c < 4; c++) tick();

        // reset after two bytes of an operation
        start = 1'b1; sub = 1'b0; a = 32'hFFFF_FFFF; b = 32'h0101_0101;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_busy_before", 64'(busy), 64'd1);
        chk("mid_sum_partial", 64'(sum), 64'h0000_0100);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_sum",  64'(sum),  64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (done) ndone++;
        end
        chk("mid_rst_no_done", 64'(ndone), 64'd0);
        chk("mid_rst_sum_after", 64'(sum), 64'd0);
        run_op("after_rst", 1'b1, 32'hA5A5_0000, 32'h0000_0001, 32'hA5A4_FFFF, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
